// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
// slave = queue side, master = fetch/decode side.
interface inst_fetch_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport slave (
    input  in_valid,
    input  in_pc,
    input  in_inst,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_pc,
    output out_inst
  );

  modport master (
    output in_valid,
    output in_pc,
    output in_inst,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_pc,
    input  out_inst
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: {pc,inst} FIFO between fetch and decode.
// Flush empties it in one cycle; outputs are zero-masked when empty.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  inst_fetch_queue_if.slave   q,
  output logic [AW:0]         count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Handshake decode; flush overrides both sides.
  always_comb begin
    full        = (count_q == FULL);
    empty       = (count_q == '0);
    q.in_ready  = ~full & reset_n;
    q.out_valid = ~empty;
    push        = q.in_valid & q.in_ready & ~flush;
    pop         = q.out_valid & q.out_ready & ~flush;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; payload is not reset, the head mux masks it.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {q.in_pc, q.in_inst};
  end

  // Head read, forced to zero when the queue is empty.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    q.out_pc   = q.out_valid ? head[63:32] : 32'h0;
    q.out_inst = q.out_valid ? head[31:0]  : 32'h0;
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: table vectors, directed
// corner sequences and random traffic against a queue model.
module tb_inst_fetch_queue;

  logic       clock;
  logic       reset_n;
  logic       flush;
  logic [2:0] count;

  inst_fetch_queue_if bus ();

  inst_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .q       (bus),
    .count   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors;
  int miscompares;
  logic [63:0] mq [$];

  typedef struct {
    bit          fl;
    bit          iv;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          ordy;
    int          e_cnt;
    bit          e_ov;
    bit          e_ir;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    logic [63:0] h;
    h = (mq.size() != 0) ? mq[0] : 64'h0;
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".out_valid"}, 32'(bus.out_valid),
        32'(mq.size() != 0));
    chk({tag, ".in_ready"}, 32'(bus.in_ready),
        32'(mq.size() != 4));
    chk({tag, ".out_pc"}, bus.out_pc, h[63:32]);
    chk({tag, ".out_inst"}, bus.out_inst, h[31:0]);
  endtask

  task automatic cycle(bit fl, bit iv, logic [31:0] pc,
                       logic [31:0] inst, bit ordy, string tag);
    bit do_push;
    bit do_pop;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = ordy;
    @(posedge clock);
    do_push = !fl && iv && (mq.size() < 4);
    do_pop  = !fl && ordy && (mq.size() > 0);
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({pc, inst});
    end
    #1;
    chk_model(tag);
  endtask

  function automatic vec_t mk(bit iv, logic [31:0] pc,
      logic [31:0] inst, bit ordy, int c, bit ov, bit ir,
      logic [31:0] epc, logic [31:0] ei);
    vec_t v;
    v.fl = 1'b0; v.iv = iv; v.pc = pc; v.inst = inst;
    v.ordy = ordy; v.e_cnt = c; v.e_ov = ov; v.e_ir = ir;
    v.e_pc = epc; v.e_inst = ei;
    return v;
  endfunction

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc = '0;
    bus.in_inst = '0;
    bus.out_ready = 1'b0;

    tbl[0] = mk(1, 32'h00400000, 32'h20080001, 0, 1, 1, 1,
                32'h00400000, 32'h20080001);
    tbl[1] = mk(1, 32'h00400004, 32'h20080002, 0, 2, 1, 1,
                32'h00400000, 32'h20080001);
    tbl[2] = mk(1, 32'h00400008, 32'h20080003, 0, 3, 1, 1,
                32'h00400000, 32'h20080001);
    tbl[3] = mk(1, 32'h0040000C, 32'h20080004, 0, 4, 1, 0,
                32'h00400000, 32'h20080001);
    tbl[4] = mk(1, 32'h00400010, 32'hDEADBEEF, 0, 4, 1, 0,
                32'h00400000, 32'h20080001);
    tbl[5] = mk(0, 32'h0, 32'h0, 1, 3, 1, 1,
                32'h00400004, 32'h20080002);
    tbl[6] = mk(0, 32'h0, 32'h0, 1, 2, 1, 1,
                32'h00400008, 32'h20080003);
    tbl[7] = mk(0, 32'h0, 32'h0, 1, 1, 1, 1,
                32'h0040000C, 32'h20080004);
    tbl[8] = mk(0, 32'h0, 32'h0, 1, 0, 0, 1,
                32'h0, 32'h0);

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_pc", bus.out_pc, 32'h0);
    chk("rst.out_inst", bus.out_inst, 32'h0);
    reset_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

    // fill / drain table
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].inst,
            tbl[i].ordy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.cnt", i), 32'(count),
          32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.ov", i), 32'(bus.out_valid),
          32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.ir", i), 32'(bus.in_ready),
          32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d.pc", i), bus.out_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.inst", i), bus.out_inst,
          tbl[i].e_inst);
    end

    // full + pop: pop happens, push refused
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 32'h00500000 + 32'(4*i), 32'h30000000 + 32'(i),
            0, "fill");
    cycle(0, 1, 32'h00500010, 32'h30000004, 1, "fullpop");
    chk("fullpop.count", 32'(count), 32'd3);
    chk("fullpop.head", bus.out_inst, 32'h30000001);
    cycle(0, 1, 32'h00500010, 32'h30000004, 0, "fullpush");
    chk("fullpush.count", 32'(count), 32'd4);

    // flush with count=3, push and pop requested
    cycle(0, 0, 32'h0, 32'h0, 1, "pre_flush");
    chk("pre_flush.count", 32'(count), 32'd3);
    cycle(1, 1, 32'h00400014, 32'h08100004, 1, "flush");
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.ov", 32'(bus.out_valid), 32'd0);
    cycle(0, 1, 32'h00400010, 32'h11111111, 0, "postflush");
    chk("postflush.pc", bus.out_pc, 32'h00400010);
    chk("postflush.count", 32'(count), 32'd1);

    // streaming from empty, wraps the pointers several times
    cycle(1, 0, 32'h0, 32'h0, 0, "clr");
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 32'h00600000 + 32'(4*i), 32'h40000000 + 32'(i),
            1, "stream");
      chk("stream.count", 32'(count), 32'd1);
      chk("stream.inst", bus.out_inst, 32'h40000000 + 32'(i));
    end

    // async reset mid-cycle with count=2
    cycle(0, 1, 32'h00600030, 32'h4000000C, 0, "pre_rst");
    chk("pre_rst.count", 32'(count), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.ov", 32'(bus.out_valid), 32'd0);
    chk("arst.inst", bus.out_inst, 32'h0);
    #1;
    reset_n = 1'b1;
    #1;
    chk("arst.in_ready", 32'(bus.in_ready), 32'd1);
    cycle(0, 1, 32'h00700000, 32'h50000001, 0, "after_rst0");
    cycle(0, 1, 32'h00700004, 32'h50000002, 1, "after_rst1");
    chk("after_rst1.inst", bus.out_inst, 32'h50000002);
    cycle(0, 0, 32'h0, 32'h0, 1, "after_rst2");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 15) == 0),
            bit'($urandom_range(0, 1)),
            $urandom, $urandom,
            bit'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
